alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports req_valid in 1 / req_ready out 1: request handshake; transfer occurs on an edge where both are 1.
REQ-004 SHALL have port req_op  in  3  ALU operation code (000 add … 111 shift-right).
REQ-005 SHALL have ports req_src1, req_src2  in  2 each: operand select, 00=A, 01=X, 10=Y, 11=req_imm.
REQ-006 SHALL have port req_dst  in  2: destination, 00=A, 01=X, 10=Y, 11=none (flags only, compare-style).
REQ-007 SHALL have port req_imm  in  8  immediate operand.
REQ-008 SHALL have ports alu_operand1, alu_operand2  out  8, alu_opcode  out  3: registered drive into the combinational ALU.
REQ-009 SHALL have ports alu_result  in  8, alu_zero  in  1, alu_carry  in  1: combinational ALU outputs.
REQ-010 SHALL have ports reg_a, reg_x, reg_y  out  8: architectural registers.
REQ-011 SHALL have ports flag_z, flag_c  out  1: status flags.
REQ-012 SHALL have port done_valid  out  1: one-cycle pulse marking a completed writeback.
REQ-013 SHALL have port op_count  out  16: completed-operation counter (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; no other states.
REQ-015 IDLE SHALL drive req_ready=1; EXEC and WB SHALL drive req_ready=0.
REQ-016 On accept edge (IDLE, req_valid=1) SHALL latch req_op into alu_opcode, the selected source values (register values as of that edge) into alu_operand1/2, and req_dst internally; next state EXEC.
REQ-017 When src1 and src2 both select 11, both operands SHALL equal req_imm.
REQ-018 req_valid=1 in EXEC/WB SHALL be ignored; request fields SHALL be sampled only on the accept edge.
REQ-019 alu_operand1/2 and alu_opcode SHALL remain stable from the accept edge until the next accept edge.
REQ-020 EXEC edge SHALL capture alu_result, alu_zero, alu_carry into internal holding registers; next state WB.
REQ-021 WB edge SHALL write the held result to reg_a/x/y per dst (none written for dst=11), write flag_z/flag_c from held flags in all cases, set done_valid=1; next state IDLE.
REQ-022 done_valid SHALL be 1 for exactly the cycle following the WB edge, 0 otherwise.
REQ-023 Latency: accept on edge N; registers/flags updated on edge N+2; earliest next accept edge N+3; throughput one op per 3 cycles.
REQ-024 An op accepted at edge N+3 SHALL read values written at edge N+2 (no stale-operand hazard).
REQ-025 Flags SHALL be passed through unmodified from the ALU; no internal arithmetic on result width.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, reg_a=reg_x=reg_y=0, flag_z=flag_c=0, alu_operand1/2=0, alu_opcode=000, done_valid=0, op_count=0; rst SHALL have priority over all other activity.
REQ-027 rst asserted in EXEC or WB SHALL abort the op: no register/flag writeback, no done_valid pulse.
REQ-028 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro ALU_SEQ_OPCOUNT_EN defined: op_count SHALL increment by 1 on each WB edge, saturating at 16'hFFFF.
REQ-030 Macro ALU_SEQ_OPCOUNT_EN undefined: op_count SHALL be constant 0 and no counter logic SHALL be present; port list unchanged.

Verification
REQ-031 Reset: rst=1 one edge, release -> regs 0x00, flag_z=0, flag_c=0, req_ready=1, done_valid=0.
REQ-032 Immediate load: op=011, src1=src2=11, imm=0x7F, dst=00 -> reg_a=0x7F at accept+2, flag_z=0, flag_c=0, done_valid pulse one cycle.
REQ-033 Add with carry-out: A=0xFF, X=0x01, op=000, src1=00, src2=01, dst=00 -> reg_a=0x00, flag_z=1, flag_c=1.
REQ-034 Compare: A=0x05, op=001, src1=00, src2=11, imm=0x05, dst=11 -> reg_a stays 0x05, flag_z=1, flag_c=0; req_valid held high during EXEC/WB -> no extra accept.
REQ-035 Abort: accept op=000 imm 0x10 to A, assert rst in EXEC -> reg_a=0x00, no done_valid pulse, req_ready=1 after release.
REQ-036 Counter: three back-to-back ops -> op_count=3 with ALU_SEQ_OPCOUNT_EN, 0 without.

Source files
------------

// File: rtl/alu_sequencer.sv
// Three-phase ALU sequencer: accepts a request, drives an external combinational
// ALU, captures its result and writes it back to A/X/Y. Optional counter: ALU_SEQ_OPCOUNT_EN.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [1:0] req_src1,
  input  logic [1:0] req_src2,
  input  logic [1:0] req_dst,
  input  logic [7:0] req_imm,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic       flag_z,
  output logic       flag_c,
  output logic       done_valid,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic       accept;
  logic       in_wb;

  logic [7:0] arch_regs_reg [3];
  logic [2:0] wr_en;
  logic [7:0] operand1_reg, operand2_reg;
  logic [2:0] opcode_reg;
  logic [1:0] dst_reg;
  logic [7:0] result_hold_reg;
  logic       zero_hold_reg, carry_hold_reg;
  logic       flag_z_reg, flag_c_reg;
  logic       done_valid_reg;
  logic [7:0] src1_value, src2_value;

  // Source 11 selects the immediate; otherwise the current architectural register.
  function automatic logic [7:0] pick_source(
    input logic [1:0] sel,
    input logic [7:0] a,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] imm
  );
    logic [7:0] value;
    unique case (sel)
      2'b00:   value = a;
      2'b01:   value = x;
      2'b10:   value = y;
      default: value = imm;
    endcase
    return value;
  endfunction

  assign accept = (state_reg == ST_IDLE) && req_valid;
  assign in_wb  = (state_reg == ST_WB);

  assign src1_value = pick_source(req_src1, arch_regs_reg[0], arch_regs_reg[1],
                                  arch_regs_reg[2], req_imm);
  assign src2_value = pick_source(req_src2, arch_regs_reg[0], arch_regs_reg[1],
                                  arch_regs_reg[2], req_imm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU drive is held from one accept to the next so the ALU output stays settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand1_reg <= 8'h00;
      operand2_reg <= 8'h00;
      opcode_reg   <= 3'b000;
      dst_reg      <= 2'b11;
    end else if (accept) begin
      operand1_reg <= src1_value;
      operand2_reg <= src2_value;
      opcode_reg   <= req_op;
      dst_reg      <= req_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_hold_reg <= 8'h00;
      zero_hold_reg   <= 1'b0;
      carry_hold_reg  <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      result_hold_reg <= alu_result;
      zero_hold_reg   <= alu_zero;
      carry_hold_reg  <= alu_carry;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_wr_en
    assign wr_en[gi] = in_wb && (dst_reg == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        arch_regs_reg[i] <= 8'h00;
      end
      flag_z_reg     <= 1'b0;
      flag_c_reg     <= 1'b0;
      done_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_en[i]) begin
          arch_regs_reg[i] <= result_hold_reg;
        end
      end
      // Flags update even for dst=11, which gives compare-style operations.
      if (in_wb) begin
        flag_z_reg <= zero_hold_reg;
        flag_c_reg <= carry_hold_reg;
      end
      done_valid_reg <= in_wb;
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] op_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= 16'h0000;
    end else if (in_wb && (op_count_reg != 16'hFFFF)) begin
      op_count_reg <= op_count_reg + 16'h0001;
    end
  end

  assign op_count = op_count_reg;
`else
  assign op_count = 16'h0000;
`endif

  assign alu_operand1 = operand1_reg;
  assign alu_operand2 = operand2_reg;
  assign alu_opcode   = opcode_reg;
  assign reg_a        = arch_regs_reg[0];
  assign reg_x        = arch_regs_reg[1];
  assign reg_y        = arch_regs_reg[2];
  assign flag_z       = flag_z_reg;
  assign flag_c       = flag_c_reg;
  assign done_valid   = done_valid_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a stub ALU and a
// transaction-level model of registers, flags and the operation count.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_src1, req_src2, req_dst;
  logic [7:0]  req_imm;
  logic [7:0]  alu_operand1, alu_operand2;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_carry;
  logic [7:0]  reg_a, reg_x, reg_y;
  logic        flag_z, flag_c, done_valid;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_reg [3];
  logic       m_z, m_c;
  int         m_count;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .req_imm(req_imm), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y),
    .flag_z(flag_z), .flag_c(flag_c), .done_valid(done_valid), .op_count(op_count)
  );

  // Returns {carry, zero, result}; subtract reports borrow as carry.
  function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] w;
    case (op)
      3'd0:    w = {1'b0, a} + {1'b0, b};
      3'd1:    w = {1'b0, a} - {1'b0, b};
      3'd2:    w = {1'b0, a & b};
      3'd3:    w = {1'b0, b};
      3'd4:    w = {1'b0, a | b};
      3'd5:    w = {1'b0, a ^ b};
      3'd6:    w = {a, 1'b0};
      default: w = {a[0], 1'b0, a[7:1]};
    endcase
    return {w[8], (w[7:0] == 8'h00), w[7:0]};
  endfunction

  always_comb begin
    {alu_carry, alu_zero, alu_result} = alu_ref(alu_opcode, alu_operand1, alu_operand2);
  end

  function automatic logic [7:0] model_src(input logic [1:0] sel, input logic [7:0] imm);
    return (sel == 2'b11) ? imm : m_reg[sel];
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef ALU_SEQ_OPCOUNT_EN
    return (m_count > 65535) ? 16'hFFFF : 16'(m_count);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_reg[i] = 8'h00;
    m_z = 1'b0;
    m_c = 1'b0;
    m_count = 0;
  endtask

  task automatic scramble_fields();
    req_op   = 3'($urandom_range(7));
    req_src1 = 2'($urandom_range(3));
    req_src2 = 2'($urandom_range(3));
    req_dst  = 2'($urandom_range(3));
    req_imm  = 8'($urandom_range(255));
  endtask

  // One full transaction; called at #1 after an edge and returns at #1 after the WB edge.
  task automatic do_op(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] d, input logic [7:0] imm, input bit hold);
    logic [7:0] e1, e2;
    logic [9:0] r;
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
      return;
    end
    e1 = model_src(s1, imm);
    e2 = model_src(s2, imm);
    r  = alu_ref(op, e1, e2);
    req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({alu_opcode, alu_operand1, alu_operand2} !== {op, e1, e2}) begin
      n_err++;
      $display("FAIL accept_drive: op/op1/op2=%h/%h/%h required %h/%h/%h",
               alu_opcode, alu_operand1, alu_operand2, op, e1, e2);
    end
    n_vec++;
    if ({req_ready, done_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL exec_handshake: ready/done=%b%b required 00", req_ready, done_valid);
    end
    req_valid = hold;
    scramble_fields();
    @(posedge clk); #1;
    n_vec++;
    if ({req_ready, done_valid, reg_a, reg_x, reg_y, flag_z, flag_c} !==
        {2'b00, m_reg[0], m_reg[1], m_reg[2], m_z, m_c}) begin
      n_err++;
      $display("FAIL wb_cycle: ready/done=%b%b a/x/y=%h/%h/%h zc=%b%b required 00 %h/%h/%h %b%b",
               req_ready, done_valid, reg_a, reg_x, reg_y, flag_z, flag_c,
               m_reg[0], m_reg[1], m_reg[2], m_z, m_c);
    end
    scramble_fields();
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (d != 2'b11) m_reg[d] = r[7:0];
    m_z = r[8];
    m_c = r[9];
    m_count++;
    n_vec++;
    if ({done_valid, req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL done_pulse: done/ready=%b%b required 11", done_valid, req_ready);
    end
    n_vec++;
    if ({reg_a, reg_x, reg_y, flag_z, flag_c} !== {m_reg[0], m_reg[1], m_reg[2], m_z, m_c}) begin
      n_err++;
      $display("FAIL writeback: a/x/y=%h/%h/%h zc=%b%b required %h/%h/%h %b%b",
               reg_a, reg_x, reg_y, flag_z, flag_c, m_reg[0], m_reg[1], m_reg[2], m_z, m_c);
    end
    n_vec++;
    if ({alu_opcode, alu_operand1, alu_operand2, op_count} !== {op, e1, e2, exp_count()}) begin
      n_err++;
      $display("FAIL hold_and_count: op/op1/op2=%h/%h/%h cnt=%h required %h/%h/%h cnt=%h",
               alu_opcode, alu_operand1, alu_operand2, op_count, op, e1, e2, exp_count());
    end
    $display("op=%0d src=%0d/%0d dst=%0d imm=%h -> a/x/y=%h/%h/%h z=%b c=%b cnt=%0d",
             op, s1, s2, d, imm, reg_a, reg_x, reg_y, flag_z, flag_c, op_count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    scramble_fields();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_vec++;
    if ({reg_a, reg_x, reg_y, flag_z, flag_c, done_valid, req_ready} !== {24'h0, 4'b0001}) begin
      n_err++;
      $display("FAIL reset_state: a/x/y=%h/%h/%h z/c/done/ready=%b%b%b%b required 0 0001",
               reg_a, reg_x, reg_y, flag_z, flag_c, done_valid, req_ready);
    end
    n_vec++;
    if ({alu_operand1, alu_operand2, alu_opcode, op_count} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_drive: op1/op2/opc/cnt=%h/%h/%h/%h required 0",
               alu_operand1, alu_operand2, alu_opcode, op_count);
    end
    $display("reset released: ready=%b", req_ready);
  endtask

  task automatic test_imm_load();
    do_op(3'b011, 2'b11, 2'b11, 2'b00, 8'h7F, 1'b0);
    n_vec++;
    if ({reg_a, flag_z, flag_c} !== {8'h7F, 2'b00}) begin
      n_err++;
      $display("FAIL imm_load: a=%h zc=%b%b required 7f 00", reg_a, flag_z, flag_c);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done_valid !== 1'b0) begin
      n_err++;
      $display("FAIL done_width: done=%b required 0", done_valid);
    end
  endtask

  task automatic test_add_carry();
    do_op(3'b011, 2'b11, 2'b11, 2'b00, 8'hFF, 1'b0);
    do_op(3'b011, 2'b11, 2'b11, 2'b01, 8'h01, 1'b0);
    do_op(3'b000, 2'b00, 2'b01, 2'b00, 8'h00, 1'b0);
    n_vec++;
    if ({reg_a, flag_z, flag_c} !== {8'h00, 2'b11}) begin
      n_err++;
      $display("FAIL add_carry: a=%h zc=%b%b required 00 11", reg_a, flag_z, flag_c);
    end
  endtask

  task automatic test_compare();
    do_op(3'b011, 2'b11, 2'b11, 2'b00, 8'h05, 1'b0);
    do_op(3'b001, 2'b00, 2'b11, 2'b11, 8'h05, 1'b1);
    n_vec++;
    if ({reg_a, flag_z, flag_c} !== {8'h05, 2'b10}) begin
      n_err++;
      $display("FAIL compare: a=%h zc=%b%b required 05 10", reg_a, flag_z, flag_c);
    end
  endtask

  // Reset lands on the EXEC edge (stage 1) or the WB edge (stage 2).
  task automatic test_abort();
    for (int stage = 1; stage <= 2; stage++) begin
      do_op(3'b011, 2'b11, 2'b11, 2'b01, 8'h33, 1'b0);
      req_op = 3'b000; req_src1 = 2'b11; req_src2 = 2'b11; req_dst = 2'b00; req_imm = 8'h10;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (stage == 2) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      n_vec++;
      if ({reg_a, reg_x, flag_z, flag_c, done_valid, req_ready} !== {16'h0, 4'b0001}) begin
        n_err++;
        $display("FAIL abort_s%0d: a/x=%h/%h z/c/done/ready=%b%b%b%b required 0 0001",
                 stage, reg_a, reg_x, flag_z, flag_c, done_valid, req_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({reg_a, done_valid, op_count} !== 25'h0) begin
        n_err++;
        $display("FAIL abort_late_s%0d: a=%h done=%b cnt=%h required 0",
                 stage, reg_a, done_valid, op_count);
      end
      $display("abort at stage %0d: a=%h done=%b ready=%b", stage, reg_a, done_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_op(3'b011, 2'b11, 2'b11, 2'b10, 8'h21, 1'b0);
    do_op(3'b000, 2'b10, 2'b10, 2'b10, 8'h00, 1'b1);
    do_op(3'b000, 2'b10, 2'b11, 2'b00, 8'h01, 1'b0);
`ifdef ALU_SEQ_OPCOUNT_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    n_vec++;
    if ({op_count, reg_y, reg_a} !== {want, 8'h42, 8'h43}) begin
      n_err++;
      $display("FAIL back_to_back: cnt=%h y=%h a=%h required %h 42 43",
               op_count, reg_y, reg_a, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
            2'($urandom_range(3)), 8'($urandom_range(255)), 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm_load();
    test_add_carry();
    test_compare();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
